// File: rtl/serdes_test_pattern_checker.sv
// Receive-side checker for the 8b10b/64b66b framed test pattern. It uses a HUNT/SYNC/LOCKED flywheel and saturating error counters.
// Latency: a word sampled at edge t is compared at t+1, and the FSM/counters update at t+2. There is no backpressure: every clock carries one word.
module serdes_test_pattern_checker #(
  parameter int CNT_W     = 16,
  parameter int ERR_W     = 8,
  parameter int BERR_W    = 32,
  parameter int LOCK_GOOD = 2,
  parameter int LOCK_BAD  = 4
) (
  input  logic              I_rxoutclk,
  input  logic              I_rxoutrst,
  input  logic [7:0]        I_rxctrl,
  input  logic [63:0]       I_rxdata,
  input  logic              I_8b10b_or_64b66b_sel,
  input  logic [CNT_W-1:0]  I_frame_len,
  input  logic              I_err_cnt_clr,
  output logic [1:0]        O_state,
  output logic              O_lock,
  output logic [ERR_W-1:0]  O_err_counter,
  output logic [BERR_W-1:0] O_bit_err_counter,
  output logic [7:0]        O_lol_counter
);

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] dat;
  } word_t;

  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;

  localparam int GW  = (LOCK_GOOD > 1) ? $clog2(LOCK_GOOD) : 1;
  localparam int BW  = (LOCK_BAD > 1) ? $clog2(LOCK_BAD) : 1;
  localparam int BSW = BERR_W + 1;

  function automatic word_t exp_word(input logic sel, input logic [CNT_W-1:0] pos);
    word_t      w;
    logic [15:0] p16;
    p16 = 16'(pos);
    if (pos == '0) begin
      w.ctrl = sel ? 8'h80 : 8'h01;
      w.dat  = sel ? 64'hFD50505050505050 : 64'h50505050505050BC;
    end else if (pos == CNT_W'(1)) begin
      w.ctrl = sel ? 8'h01 : 8'h00;
      w.dat  = sel ? 64'h50505050505050FB : 64'h5050505050505050;
    end else begin
      w.ctrl = 8'h00;
      w.dat  = {p16, 16'h0000, p16, p16};
    end
    return w;
  endfunction

  function automatic logic is_marker(input logic sel, input word_t w);
    return sel ? (w.ctrl[7] && (w.dat[63:56] == 8'hFD))
               : (w.ctrl[0] && (w.dat[7:0] == 8'hBC));
  endfunction

  function automatic logic [6:0] popcnt72(input logic [71:0] x);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 72; i++) n = n + 7'(x[i]);
    return n;
  endfunction

  logic             sel_q;
  logic [CNT_W-1:0] len_q;
  logic             cfg_chg;
  logic             fe_hunt;
  logic [CNT_W-1:0] fe_pos;
  logic [CNT_W-1:0] last_pos;
  logic [CNT_W-1:0] cur_pos;
  logic [CNT_W-1:0] nxt_pos;
  logic             in_marker;
  word_t            rx_in;
  word_t            rx1;
  word_t            exp1;
  logic             align1;
  logic             last1;
  logic             err2;
  logic [6:0]       bits2;
  logic             align2;
  logic             last2;
  state_t           state;
  logic             lock;
  logic [GW-1:0]    good_cnt;
  logic [BW-1:0]    bad_cnt;
  logic             lol_hit;
  logic             to_hunt;
  logic [ERR_W-1:0] err_cnt;
  logic [BERR_W-1:0] bit_cnt;
  logic [7:0]       lol_cnt;
  logic [BSW-1:0]   bit_sum;

  assign rx_in     = '{ctrl: I_rxctrl, dat: I_rxdata};
  assign cfg_chg   = (I_8b10b_or_64b66b_sel != sel_q) || (I_frame_len != len_q);
  assign last_pos  = (len_q < CNT_W'(2)) ? CNT_W'(2) : len_q;
  assign in_marker = is_marker(sel_q, rx_in);
  assign cur_pos   = fe_hunt ? '0 : fe_pos;
  assign nxt_pos   = (cur_pos == last_pos) ? '0 : cur_pos + CNT_W'(1);
  assign lol_hit   = (state == LOCKED) && err2 && (bad_cnt == BW'(LOCK_BAD - 1));
  assign to_hunt   = cfg_chg || ((state == SYNC) && err2) || lol_hit;
  assign bit_sum   = {1'b0, bit_cnt} + BSW'(bits2);

  // Front end: aligns on the incoming marker itself, so the expected word is ready as a registered operand.
  // It re-enters hunt on the same edge as the FSM, which leaves in-flight words tagged as non-aligning.
  always_ff @(posedge I_rxoutclk) begin
    if (I_rxoutrst) begin
      sel_q   <= I_8b10b_or_64b66b_sel;
      len_q   <= I_frame_len;
      fe_hunt <= 1'b1;
      fe_pos  <= '0;
      rx1     <= '0;
      exp1    <= '0;
      align1  <= 1'b0;
      last1   <= 1'b0;
    end else begin
      sel_q  <= I_8b10b_or_64b66b_sel;
      len_q  <= I_frame_len;
      rx1    <= rx_in;
      exp1   <= exp_word(sel_q, cur_pos);
      align1 <= fe_hunt && in_marker && !cfg_chg;
      last1  <= (cur_pos == last_pos);
      if (to_hunt) begin
        fe_hunt <= 1'b1;
        fe_pos  <= '0;
      end else if (!fe_hunt || in_marker) begin
        fe_hunt <= 1'b0;
        fe_pos  <= nxt_pos;
      end
    end
  end

  always_ff @(posedge I_rxoutclk) begin
    if (I_rxoutrst) begin
      err2     <= 1'b0;
      bits2    <= '0;
      align2   <= 1'b0;
      last2    <= 1'b0;
      state    <= HUNT;
      lock     <= 1'b0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      err_cnt  <= '0;
      bit_cnt  <= '0;
      lol_cnt  <= '0;
    end else begin
      err2   <= (rx1 != exp1);
      bits2  <= popcnt72(rx1 ^ exp1);
      align2 <= align1 && !cfg_chg;
      last2  <= last1;

      if (cfg_chg) begin
        state    <= HUNT;
        lock     <= 1'b0;
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else begin
        case (state)
          HUNT: begin
            if (align2) begin
              state    <= SYNC;
              good_cnt <= '0;
            end
          end
          SYNC: begin
            if (err2) begin
              state <= HUNT;
            end else if (last2) begin
              if (good_cnt == GW'(LOCK_GOOD - 1)) begin
                state   <= LOCKED;
                lock    <= 1'b1;
                bad_cnt <= '0;
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end
          end
          LOCKED: begin
            if (lol_hit) begin
              state <= HUNT;
              lock  <= 1'b0;
            end else if (err2) begin
              bad_cnt <= bad_cnt + BW'(1);
            end else begin
              bad_cnt <= '0;
            end
          end
          default: begin
            state <= HUNT;
            lock  <= 1'b0;
          end
        endcase
      end

      if (I_err_cnt_clr) begin
        err_cnt <= '0;
        bit_cnt <= '0;
        lol_cnt <= '0;
      end else if ((state == LOCKED) && !cfg_chg && err2) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
        bit_cnt <= bit_sum[BERR_W] ? '1 : bit_sum[BERR_W-1:0];
        if (lol_hit && (lol_cnt != 8'hFF)) lol_cnt <= lol_cnt + 8'd1;
      end
    end
  end

  assign O_state           = state;
  assign O_lock            = lock;
  assign O_err_counter     = err_cnt;
  assign O_bit_err_counter = bit_cnt;
  assign O_lol_counter     = lol_cnt;

endmodule

// File: tb/tb_serdes_test_pattern_checker.sv
// Directed bench for serdes_test_pattern_checker: lock timing, error counting, loss of lock, saturation, clear and config change.
module tb_serdes_test_pattern_checker;

  localparam int CNT_W  = 16;
  localparam int ERR_W  = 4;
  localparam int BERR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rxctrl;
  logic [63:0]       rxdata;
  logic              sel;
  logic [CNT_W-1:0]  flen;
  logic              clr;
  logic [1:0]        state;
  logic              lock;
  logic [ERR_W-1:0]  errc;
  logic [BERR_W-1:0] berrc;
  logic [7:0]        lolc;

  int checks = 0;
  int errors = 0;
  int bpos   = 0;

  always #5 clk = ~clk;

  serdes_test_pattern_checker #(
    .CNT_W(CNT_W), .ERR_W(ERR_W), .BERR_W(BERR_W), .LOCK_GOOD(2), .LOCK_BAD(4)
  ) dut (
    .I_rxoutclk(clk),
    .I_rxoutrst(rst),
    .I_rxctrl(rxctrl),
    .I_rxdata(rxdata),
    .I_8b10b_or_64b66b_sel(sel),
    .I_frame_len(flen),
    .I_err_cnt_clr(clr),
    .O_state(state),
    .O_lock(lock),
    .O_err_counter(errc),
    .O_bit_err_counter(berrc),
    .O_lol_counter(lolc)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] pat(input logic s, input int p);
    logic [15:0] q;
    q = p[15:0];
    if (p == 0)      return s ? {8'h80, 64'hFD50505050505050} : {8'h01, 64'h50505050505050BC};
    else if (p == 1) return s ? {8'h01, 64'h50505050505050FB} : {8'h00, 64'h5050505050505050};
    else             return {8'h00, q, 16'h0000, q, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the pattern word at bpos (optionally corrupted), let one edge sample it, advance bpos.
  task automatic send(input logic [63:0] dx, input logic [7:0] cx);
    logic [71:0] w;
    w = pat(sel, bpos);
    rxctrl = w[71:64] ^ cx;
    rxdata = w[63:0] ^ dx;
    tick();
    bpos = (bpos == int'(flen)) ? 0 : bpos + 1;
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) send(64'h0, 8'h00);
  endtask

  task automatic wait_lock(input string tag, input int lim);
    for (int i = 0; i < lim && lock !== 1'b1; i++) send(64'h0, 8'h00);
    check(tag, lock, 1);
    check({tag, "_state"}, state, 2);
  endtask

  initial begin
    sel = 1'b0; flen = 16'd7; clr = 1'b0; rst = 1'b1;
    rxctrl = 8'h00; rxdata = 64'h0;

    for (int i = 0; i < 4; i++) begin
      rxdata = {$urandom, $urandom};
      rxctrl = 8'($urandom);
      tick();
      check("rst_state", state, 0);
      check("rst_lock", lock, 0);
    end
    check("rst_err", errc, 0);
    check("rst_berr", berrc, 0);
    check("rst_lol", lolc, 0);
    rst = 1'b0;

    // Non-marker idle words keep the checker hunting.
    rxctrl = 8'h00; rxdata = 64'h1234;
    tick(); tick(); tick();
    check("hunt_idle", state, 0);

    // 8b10b, L=8: marker sampled at edge t0 (k=0).
    bpos = 0;
    for (int k = 0; k <= 18; k++) begin
      send(64'h0, 8'h00);
      if (k == 1)  check("sync_t0p1", state, 0);
      if (k == 2)  check("sync_t0p2", state, 1);
      if (k == 16) check("lock_t0p16", lock, 0);
      if (k == 17) begin
        check("lock_t0p17", lock, 1);
        check("locked_t0p17", state, 2);
      end
    end
    check("clean_err", errc, 0);
    check("clean_berr", berrc, 0);

    // Mode toggle while locked forces HUNT without counting loss of lock.
    sel = 1'b1; bpos = 0;
    send_clean(2);
    check("sel_hunt_state", state, 0);
    check("sel_hunt_lock", lock, 0);
    check("sel_hunt_lol", lolc, 0);
    wait_lock("relock_64b66b", 70);

    // Frame length change to L=10.
    flen = 16'd9; bpos = 0;
    send_clean(2);
    check("len_hunt_state", state, 0);
    wait_lock("relock_len10", 80);

    // Single-bit error at p=5, then a fully inverted data word.
    while (bpos != 5) send(64'h0, 8'h00);
    send(64'h1, 8'h00);
    send_clean(3);
    check("bit0_err", errc, 1);
    check("bit0_berr", berrc, 1);
    check("bit0_lock", lock, 1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    send_clean(3);
    check("inv_err", errc, 2);
    check("inv_berr", berrc, 65);
    check("inv_lock", lock, 1);

    clr = 1'b1;
    send(64'h0, 8'h00);
    clr = 1'b0;
    check("clr_err", errc, 0);
    check("clr_berr", berrc, 0);
    check("clr_lock", lock, 1);

    // Four consecutive corrupted words drop lock.
    repeat (4) send(64'h1, 8'h00);
    send_clean(2);
    check("lol_lock", lock, 0);
    check("lol_state", state, 0);
    check("lol_cnt", lolc, 1);
    check("lol_err", errc, 4);
    check("lol_berr", berrc, 4);
    wait_lock("relock_after_lol", 80);
    check("lol_hold", lolc, 1);
    check("lol_err_hold", errc, 4);

    // Isolated errors saturate the 4-bit word counter without losing lock.
    repeat (20) begin
      send(64'h1, 8'h00);
      send_clean(2);
    end
    check("sat_err", errc, 15);
    check("sat_berr", berrc, 24);
    check("sat_lock", lock, 1);
    send(64'h1, 8'h00);
    send_clean(2);
    check("sat_err_hold", errc, 15);
    check("sat_berr_add", berrc, 25);

    // Clear lands on the same edge as an increment.
    send(64'h1, 8'h00);
    send(64'h0, 8'h00);
    clr = 1'b1;
    send(64'h0, 8'h00);
    clr = 1'b0;
    check("clrwin_err", errc, 0);
    check("clrwin_berr", berrc, 0);
    check("clrwin_lol", lolc, 0);
    check("clrwin_lock", lock, 1);
    send_clean(2);
    check("clrwin_err_after", errc, 0);

    // Reset mid-operation.
    rst = 1'b1;
    send(64'h0, 8'h00);
    rst = 1'b0;
    check("midrst_state", state, 0);
    check("midrst_lock", lock, 0);
    check("midrst_lol", lolc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serdes_test_pattern_checker.md
# serdes_test_pattern_checker

Parametrised next-generation receive-side checker for the SERDES loopback/bring-up path. It checks the CPRI-style (8b10b) or 64b66b framed test pattern produced by the matching generator on the recovered-clock domain. It supports a runtime-programmable frame length and a HUNT/SYNC/LOCKED alignment state machine with flywheel. It keeps saturating word-error, bit-error and loss-of-lock counters for the CPU register block.

## Interface
Parameters:
- CNT_W, 16, frame position counter width (8..16); pattern uses position zero-extended to 16 bits
- ERR_W, 8, word-error counter width
- BERR_W, 32, bit-error counter width
- LOCK_GOOD, 2, consecutive clean frames in SYNC required to enter LOCKED (>=1)
- LOCK_BAD, 4, consecutive errored words in LOCKED that drop lock (>=1)

Ports:
- I_rxoutclk  in  1  recovered receive clock; only clock
- I_rxoutrst  in  1  reset, synchronous, active-high
- I_rxctrl  in  8  per-byte control flags
- I_rxdata  in  64  receive data word
- I_8b10b_or_64b66b_sel  in  1  0 = 8b10b, 1 = 64b66b
- I_frame_len  in  CNT_W  frame length minus one (L = value+1 words); values <2 treated as 2
- I_err_cnt_clr  in  1  synchronous clear of all counters
- O_state  out  2  0 = HUNT, 1 = SYNC, 2 = LOCKED
- O_lock  out  1  high in LOCKED
- O_err_counter  out  ERR_W  saturating errored-word count
- O_bit_err_counter  out  BERR_W  saturating errored-bit count
- O_lol_counter  out  8  saturating loss-of-lock count

## Operation
- Expected word at position p (0..L-1):
  - 8b10b, p=0: data 0x50505050505050BC, ctrl 0x01. p=1: data 0x5050505050505050, ctrl 0x00.
  - 64b66b, p=0: data 0xFD50505050505050, ctrl 0x80. p=1: data 0x50505050505050FB, ctrl 0x01.
  - p>=2: data {p16, 16'h0000, p16, p16}, ctrl 0x00.
- Sync marker: 8b10b requires ctrl[0]=1 and data[7:0]=0xBC. 64b66b requires ctrl[7]=1 and data[63:56]=0xFD.
- Word error: data or ctrl differs from the expected word. Bit count = popcount of (data XOR exp) plus popcount of (ctrl XOR exp), 0..72.
- HUNT:
  - No comparison is made.
  - A marker word sets position to 0 for that word and moves the FSM to SYNC, with the good-frame count at 0.
- SYNC:
  - Every word is compared.
  - Any word error moves the FSM to HUNT.
  - On the last word of an error-free frame (p=L-1), the good-frame count increments. When it reaches LOCK_GOOD, the FSM moves to LOCKED.
  - The detecting frame counts toward LOCK_GOOD.
  - Counters do not change in SYNC.
- LOCKED (flywheel):
  - The position free-runs 0..L-1 and wraps to 0. It never re-aligns on a marker.
  - Each errored word adds 1 to O_err_counter and its bit count to O_bit_err_counter.
  - The consecutive-bad count resets on any clean word.
  - When the consecutive-bad count reaches LOCK_BAD, the FSM moves to HUNT and O_lol_counter increments.
  - A marker at an unexpected position is an ordinary word error.
- Config change: a change of I_8b10b_or_64b66b_sel or I_frame_len (compared against a registered copy) forces HUNT from any state. It does not increment O_lol_counter.
- Counters saturate at all-ones and never wrap.
- I_err_cnt_clr zeroes all three counters. Clear wins over a same-cycle increment (result 0). Clear does not affect the FSM.

## Timing
- Reset: O_state=0, O_lock=0, all counters 0, position 0, internal counts 0, registered config captured from inputs.
- Reset mid-operation returns to HUNT on the next edge. No lol increment.
- Pipeline: word sampled at edge t; compare/popcount result registered at t+1; FSM, O_lock and counters reflect it after edge t+2.
- The expected-word generator runs one cycle ahead so the compare stage uses registered operands only.
- Config-change forced HUNT is visible at most 2 edges after the change. Words in flight are discarded.
- Throughput: one word per clock, no stall or valid; every cycle is a word.

## Test plan
- Reset with random rx data → O_state=0, O_lock=0, O_err_counter=0, O_bit_err_counter=0, O_lol_counter=0; these values hold while I_rxoutrst=1.
- 8b10b, I_frame_len=7, clean stream, first marker at edge t0 → O_state=1 after t0+2; O_lock=1 after edge t0+17; counters stay 0.
- 64b66b, I_frame_len=9, locked, one word at p=5 with data bit 0 flipped → O_err_counter=1, O_bit_err_counter=1, O_lock stays 1; one word with all 64 data bits inverted → bit counter +64.
- Locked, 4 consecutive corrupted words → O_lock=0, O_state=0, O_lol_counter=1, O_err_counter=4; clean stream resumes → relock after 2 frames, lol stays 1.
- ERR_W=4, 20 isolated errored words while locked → O_err_counter=15 and holds; I_err_cnt_clr asserted in the same cycle as an error increment → all counters 0.
- Locked, toggle I_8b10b_or_64b66b_sel → O_state=0 within 2 edges, O_lol_counter unchanged; relock in the new mode.
